// File: rtl/uart_rx_os.sv
// ============================================================================
//  uart_rx_os -- oversampling UART receiver with 3-sample majority voting,
//                optional parity check and stop/break detection.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_os #(
  parameter int OVERSAMPLE    = 16,
  parameter int NUM_DATA_BITS = 8,
  parameter int PARITY        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     enable,
  input  logic                     rx,
  output logic [NUM_DATA_BITS-1:0] data,
  output logic                     valid,
  output logic                     busy,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int c_tw = $clog2(OVERSAMPLE);
  localparam int c_bw = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
  localparam logic [c_tw-1:0] c_samp_a   = c_tw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tw-1:0] c_samp_b   = c_tw'(OVERSAMPLE / 2);
  localparam logic [c_tw-1:0] c_decide   = c_tw'(OVERSAMPLE / 2 + 1);
  localparam logic [c_tw-1:0] c_last     = c_tw'(OVERSAMPLE - 1);
  localparam logic [c_bw-1:0] c_last_bit = c_bw'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_s_q;
  logic [c_tw-1:0]          tick_q, tick_d;
  logic [c_bw-1:0]          bit_q, bit_d;
  logic [1:0]               samp_q, samp_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic [NUM_DATA_BITS-1:0] data_q, data_d;
  logic                     par_bad_q, par_bad_d;
  logic                     valid_q, valid_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;

  logic w_vote;
  logic w_wrap;
  logic w_decide;
  logic w_par_exp;

  assign w_vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign w_wrap   = (tick_q == c_last);
  assign w_decide = (tick_q == c_decide);

  generate
    if (PARITY == 2) begin : g_par_odd
      assign w_par_exp = ~^shift_q;
    end else begin : g_par_even
      assign w_par_exp = ^shift_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      tick_q    <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    if (sample_tick) begin
      if (state_q != ST_IDLE && state_q != ST_BREAK) begin
        tick_d = w_wrap ? '0 : tick_q + c_tw'(1);
        if (tick_q == c_samp_a) samp_d[0] = rx_s_q;
        if (tick_q == c_samp_b) samp_d[1] = rx_s_q;
      end

      case (state_q)
        ST_IDLE: begin
          // The detecting tick is tick 0, so the next tick is tick 1.
          if (!rx_s_q) begin
            state_d = ST_START;
            tick_d  = c_tw'(1);
          end
        end
        ST_START: begin
          if (w_decide && w_vote) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end else if (w_wrap) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (w_decide) shift_d[bit_q] = w_vote;
          if (w_wrap) begin
            if (bit_q == c_last_bit) begin
              state_d = (PARITY == 0) ? ST_STOP : ST_PARITY;
            end else begin
              bit_d = bit_q + c_bw'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_decide) par_bad_d = w_vote ^ w_par_exp;
          if (w_wrap) state_d = ST_STOP;
        end
        ST_STOP: begin
          // Leaving at mid-bit gives headroom for back-to-back frames and baud skew.
          if (w_decide) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = par_bad_q;
            ferr_d  = ~w_vote;
            state_d = w_vote ? ST_IDLE : ST_BREAK;
            tick_d  = '0;
          end
        end
        ST_BREAK: begin
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

`default_nettype wire
